// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Modules derive their own widths from parameters; these constants match the defaults.
package fifo_arb_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int DSIZE_DEF     = 8;
  localparam int MAX_BURST_DEF = 4;

  localparam int IDW = $clog2(NREQ_DEF);
  localparam int BCW = $clog2(MAX_BURST_DEF + 1);

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_ACTIVE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping modulo NREQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         pick_onehot,
  output logic [$clog2(NREQ)-1:0] pick_idx,
  output logic                    pick_any
);

  localparam int GIDW = $clog2(NREQ);

  // Scan NREQ candidates starting at rr_ptr; the first hit wins.
  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    pick_any    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      automatic logic [GIDW-1:0] cand = GIDW'((int'(rr_ptr) + i) % NREQ);
      if (!pick_any && req[cand]) begin
        pick_any          = 1'b1;
        pick_idx          = cand;
        pick_onehot       = '0;
        pick_onehot[cand] = 1'b1;
      end else begin
        pick_any = pick_any;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing the FIFO write port between NREQ requesters.
// Grants are registered; winc/wdata/req_ready follow the current grant combinationally.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DSIZE     = DSIZE_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy
);

  localparam int GIDW = $clog2(NREQ);
  localparam int CNTW = $clog2(MAX_BURST + 1);
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_BURST - 1);
  localparam logic [GIDW-1:0] LAST_ID   = GIDW'(NREQ - 1);

  arb_state_e                 state_r, state_nxt_s;
  logic [NREQ-1:0]            gnt_r, gnt_nxt_s;
  logic [GIDW-1:0]            gnt_id_r, gnt_id_nxt_s;
  logic [GIDW-1:0]            rr_ptr_r, rr_ptr_nxt_s;
  logic [CNTW-1:0]            beat_r, beat_nxt_s;
  logic                       busy_r, busy_nxt_s;

  logic [NREQ-1:0]            pick_onehot_s;
  logic [GIDW-1:0]            pick_idx_s;
  logic                       pick_any_s;
  logic [NREQ-1:0][DSIZE-1:0] req_words_s;
  logic                       active_s, sel_valid_s, sel_last_s, xfer_s, release_s;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req         (req_valid),
    .rr_ptr      (rr_ptr_r),
    .pick_onehot (pick_onehot_s),
    .pick_idx    (pick_idx_s),
    .pick_any    (pick_any_s)
  );

  assign req_words_s = req_data;
  assign active_s    = (state_r == ARB_ACTIVE);
  assign sel_valid_s = req_valid[gnt_id_r];
  assign sel_last_s  = req_last[gnt_id_r];

  // wfull gates every transfer, so winc can never assert into a full FIFO.
  assign xfer_s    = active_s & sel_valid_s & ~wfull;
  assign release_s = active_s & ((xfer_s & (sel_last_s | (beat_r == LAST_BEAT))) | ~sel_valid_s);

  assign winc      = xfer_s;
  assign wdata     = req_words_s[gnt_id_r];
  assign req_ready = (active_s && !wfull) ? gnt_r : {NREQ{1'b0}};
  assign gnt       = gnt_r;
  assign gnt_id    = gnt_id_r;
  assign busy      = busy_r;

  // Next-state, grant, beat counter and round-robin pointer update.
  always_comb begin
    state_nxt_s  = state_r;
    gnt_nxt_s    = gnt_r;
    gnt_id_nxt_s = gnt_id_r;
    rr_ptr_nxt_s = rr_ptr_r;
    beat_nxt_s   = beat_r;
    busy_nxt_s   = busy_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_any_s) begin
          state_nxt_s  = ARB_ACTIVE;
          gnt_nxt_s    = pick_onehot_s;
          gnt_id_nxt_s = pick_idx_s;
          beat_nxt_s   = '0;
          busy_nxt_s   = 1'b1;
        end else begin
          state_nxt_s  = ARB_IDLE;
        end
      end
      ARB_ACTIVE: begin
        if (release_s) begin
          state_nxt_s  = ARB_IDLE;
          gnt_nxt_s    = '0;
          beat_nxt_s   = '0;
          busy_nxt_s   = 1'b0;
          rr_ptr_nxt_s = (gnt_id_r == LAST_ID) ? {GIDW{1'b0}} : gnt_id_r + GIDW'(1);
        end else if (xfer_s) begin
          beat_nxt_s   = beat_r + CNTW'(1);
        end else begin
          beat_nxt_s   = beat_r;
        end
      end
      default: begin
        state_nxt_s  = ARB_IDLE;
        gnt_nxt_s    = '0;
        beat_nxt_s   = '0;
        busy_nxt_s   = 1'b0;
      end
    endcase
  end

  // State registers; reset clears the grant immediately so winc drops without a clock.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_r  <= ARB_IDLE;
      gnt_r    <= '0;
      gnt_id_r <= '0;
      rr_ptr_r <= '0;
      beat_r   <= '0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      gnt_r    <= gnt_nxt_s;
      gnt_id_r <= gnt_id_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      beat_r   <= beat_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: per-requester word queues drive the arbiter; a grant-ownership model predicts outputs.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;

  typedef struct packed {
    logic             last;
    logic [DSIZE-1:0] data;
  } word_t;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid, req_last, req_ready, gnt;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  wfull, winc, busy;
  logic [DSIZE-1:0]      wdata;
  logic [IDW-1:0]        gnt_id;

  word_t           src_q [NREQ][$];
  logic [NREQ-1:0] en;
  logic            full_drv;
  int              n_cmp = 0;
  int              n_err = 0;
  int              m_owner, m_words, m_next;
  logic            prev_busy;
  logic [7:0]      wr_data_log [$];
  int              gnt_log [$];

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic word_t mk(input logic last, input logic [7:0] data);
    word_t w;
    w.last = last;
    w.data = data;
    return w;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_words   = 0;
    m_next    = 0;
    prev_busy = 1'b0;
  endtask

  // Present each requester's head word; idle requesters carry junk data/last.
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*DSIZE +: DSIZE] = src_q[i][0].data;
        req_last[i] = src_q[i][0].last;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DSIZE +: DSIZE] = 8'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
    wfull = full_drv;
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] e_gnt, e_rdy;
    logic            e_busy, e_winc;
    e_busy = (m_owner >= 0);
    e_gnt  = '0;
    e_rdy  = '0;
    e_winc = 1'b0;
    if (e_busy) begin
      e_gnt[m_owner] = 1'b1;
      e_winc = req_valid[m_owner] && !wfull;
      e_rdy  = wfull ? '0 : e_gnt;
    end
    chk_val("busy", 32'(busy), 32'(e_busy));
    chk_val("gnt", 32'(gnt), 32'(e_gnt));
    chk_val("winc", 32'(winc), 32'(e_winc));
    chk_val("req_ready", 32'(req_ready), 32'(e_rdy));
    if (e_busy) chk_val("gnt_id", 32'(gnt_id), m_owner);
    if (e_winc) chk_val("wdata", 32'(wdata), 32'(src_q[m_owner][0].data));
  endtask

  // Ownership view: a grant lasts until last, MAX_BURST words, or the owner drops valid.
  task automatic model_step();
    if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        automatic int c = (m_next + k) % NREQ;
        if (m_owner < 0 && req_valid[c]) begin
          m_owner = c;
          m_words = 0;
        end
      end
    end else if (!req_valid[m_owner]) begin
      m_next  = (m_owner + 1) % NREQ;
      m_owner = -1;
    end else if (!wfull) begin
      m_words++;
      if (req_last[m_owner] || m_words == MAX_BURST) begin
        m_next  = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
  endtask

  task automatic cyc();
    @(negedge wclk);
    drive();
    #1;
    check_outputs();
    if (busy && !prev_busy) gnt_log.push_back(int'(gnt_id));
    prev_busy = busy;
    if (winc) wr_data_log.push_back(wdata);
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
    end
    model_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_writes(input string tag, input int n);
    for (int i = 0; i < 20 && wr_data_log.size() < n; i++) cyc();
    chk_val(tag, wr_data_log.size(), n);
  endtask

  task automatic reset_all();
    @(negedge wclk);
    en       = '0;
    full_drv = 1'b0;
    drive();
    wrst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    wr_data_log.delete();
    gnt_log.delete();
    model_reset();
    @(posedge wclk);
    #2;
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n    = 1'b0;
    en        = '0;
    full_drv  = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
    model_reset();
    reset_all();
    #1;
    chk_val("rst_gnt", 32'(gnt), 32'd0);
    chk_val("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_winc", 32'(winc), 32'd0);
    chk_val("rst_ready", 32'(req_ready), 32'd0);

    // Single requester burst, then confirm the pointer moved past req0.
    en = '1;
    src_q[0].push_back(mk(1'b0, 8'h11));
    src_q[0].push_back(mk(1'b0, 8'h22));
    src_q[0].push_back(mk(1'b1, 8'h33));
    run(6);
    chk_val("s1_nwr", wr_data_log.size(), 3);
    chk_val("s1_w0", 32'(wr_data_log[0]), 32'h11);
    chk_val("s1_w1", 32'(wr_data_log[1]), 32'h22);
    chk_val("s1_w2", 32'(wr_data_log[2]), 32'h33);
    src_q[0].push_back(mk(1'b1, 8'h5A));
    src_q[1].push_back(mk(1'b1, 8'h5B));
    run(6);
    chk_val("s1_rr_next", gnt_log[1], 1);
    chk_val("s1_rr_wrap", gnt_log[2], 0);

    // Everyone valid with single-word bursts: strict rotation.
    reset_all();
    en = '1;
    for (int i = 0; i < NREQ; i++) src_q[i].push_back(mk(1'b1, 8'(8'h40 + i)));
    src_q[0].push_back(mk(1'b1, 8'h50));
    run(12);
    chk_val("s2_ngnt", gnt_log.size(), 5);
    for (int i = 0; i < 5; i++) chk_val("s2_order", gnt_log[i], i % NREQ);

    // Burst cap forces release; the same requester is regranted after one idle cycle.
    reset_all();
    en = '1;
    for (int i = 0; i < 7; i++) src_q[2].push_back(mk(1'b0, 8'(8'hA0 + i)));
    run(16);
    chk_val("s3_nwr", wr_data_log.size(), 7);
    chk_val("s3_ngnt", gnt_log.size(), 2);
    chk_val("s3_w6", 32'(wr_data_log[6]), 32'hA6);

    // wfull stall mid-burst.
    reset_all();
    en = '1;
    src_q[1].push_back(mk(1'b0, 8'hB1));
    src_q[1].push_back(mk(1'b0, 8'hB2));
    src_q[1].push_back(mk(1'b1, 8'hB3));
    wait_writes("s4_first", 1);
    full_drv = 1'b1;
    run(5);
    chk_val("s4_stalled", wr_data_log.size(), 1);
    full_drv = 1'b0;
    run(4);
    chk_val("s4_nwr", wr_data_log.size(), 3);
    chk_val("s4_w1", 32'(wr_data_log[1]), 32'hB2);

    // Requester drop releases the grant; pending req0 follows.
    reset_all();
    en = '1;
    src_q[3].push_back(mk(1'b0, 8'hC1));
    src_q[3].push_back(mk(1'b0, 8'hC2));
    src_q[3].push_back(mk(1'b1, 8'hC3));
    cyc();
    src_q[0].push_back(mk(1'b1, 8'hD0));
    wait_writes("s5_first", 1);
    en[3] = 1'b0;
    run(6);
    chk_val("s5_nwr", wr_data_log.size(), 2);
    chk_val("s5_w1", 32'(wr_data_log[1]), 32'hD0);
    chk_val("s5_g0", gnt_log[0], 3);
    chk_val("s5_g1", gnt_log[1], 0);

    // Asynchronous reset mid-burst; the in-flight word is retried afterwards.
    reset_all();
    en = '1;
    for (int i = 0; i < 4; i++) src_q[0].push_back(mk(i == 3, 8'(8'hE0 + i)));
    src_q[1].push_back(mk(1'b1, 8'hF1));
    wait_writes("s6_first", 1);
    @(negedge wclk);
    drive();
    #1;
    check_outputs();
    #1;
    wrst_n = 1'b0;
    #1;
    chk_val("s6_winc", 32'(winc), 32'd0);
    chk_val("s6_gnt", 32'(gnt), 32'd0);
    chk_val("s6_busy", 32'(busy), 32'd0);
    chk_val("s6_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge wclk);
    #2;
    wrst_n = 1'b1;
    run(12);
    chk_val("s6_regrant", gnt_log[1], 0);
    chk_val("s6_next", gnt_log[2], 1);
    chk_val("s6_nwr", wr_data_log.size(), 5);
    chk_val("s6_retry", 32'(wr_data_log[1]), 32'hE1);

    // Randomized traffic, drops and backpressure.
    reset_all();
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() < 3 && $urandom_range(3, 0) == 0)
          src_q[i].push_back(mk($urandom_range(2, 0) == 0, 8'($urandom)));
        en[i] = ($urandom_range(7, 0) != 0);
      end
      full_drv = ($urandom_range(3, 0) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
